ahb_manager_burst_splitter: RTL and testbench

Request front-end for the AHB manager. It accepts one linear transfer request (start address, beat count, beat size) and splits it into a sequence of AHB burst commands. Each command carries an hburst encoding and beat count that never crosses a 1 KB address boundary. It sits directly upstream of the manager's bus engine and feeds it one command at a time over a valid/ready handshake.

---
 rtl/ahb_manager_burst_splitter.sv | 158 +++++++++++++++
 tb/tb_ahb_manager_burst_splitter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_manager_burst_splitter.sv
// Splits one linear transfer request into AHB burst commands that never cross a 1 KB boundary.
// Optional build macro AHB_SPLIT_ALIGN_CHECK_EN: reject misaligned requests with an o_err pulse.
module ahb_manager_burst_splitter #(
    parameter int LEN_W = 16
) (
    input  logic             i_hclk,
    input  logic             i_hreset_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [31:0]      i_req_addr,
    input  logic [LEN_W-1:0] i_req_len,
    input  logic [2:0]       i_req_size,
    output logic             o_cmd_valid,
    input  logic             i_cmd_ready,
    output logic [31:0]      o_cmd_addr,
    output logic [2:0]       o_cmd_hburst,
    output logic [4:0]       o_cmd_beats,
    output logic [2:0]       o_cmd_size,
    output logic             o_cmd_last,
    output logic             o_done,
    output logic             o_err,
    output logic             o_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;
    localparam logic [2:0] HB_INCR4  = 3'd3;
    localparam logic [2:0] HB_INCR8  = 3'd5;
    localparam logic [2:0] HB_INCR16 = 3'd7;

    logic [1:0]       state;
    logic [31:0]      cur_addr;
    logic [LEN_W-1:0] remain;
    logic [2:0]       cur_size;

    logic             fits16;
    logic             fits8;
    logic             fits4;
    logic [10:0]      to_boundary;
    logic [4:0]       remain_cap;
    logic [4:0]       nxt_beats;
    logic [2:0]       nxt_hburst;
    logic [31:0]      step;
    logic [LEN_W-1:0] remain_after;
    logic [31:0]      align_mask;
    logic             misaligned;

    assign align_mask = ~((32'd1 << i_req_size) - 32'd1);

`ifdef AHB_SPLIT_ALIGN_CHECK_EN
    assign misaligned = |(i_req_addr & ~align_mask);
`else
    assign misaligned = 1'b0;
    assign o_err      = 1'b0;
`endif

    assign o_req_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);

    // Fits(n) is evaluated in 33 bits so an address wrap counts as a 1 KB crossing.
    always_comb begin
        fits16 = ((({1'b0, cur_addr} + (33'd15 << cur_size)) >> 10) == ({1'b0, cur_addr} >> 10));
        fits8  = ((({1'b0, cur_addr} + (33'd7  << cur_size)) >> 10) == ({1'b0, cur_addr} >> 10));
        fits4  = ((({1'b0, cur_addr} + (33'd3  << cur_size)) >> 10) == ({1'b0, cur_addr} >> 10));
        to_boundary = (11'd1024 - {1'b0, cur_addr[9:0]}) >> cur_size;
        remain_cap  = (remain >= LEN_W'(16)) ? 5'd16 : remain[4:0];
        nxt_beats   = 5'd1;
        nxt_hburst  = HB_SINGLE;
        if ((remain >= LEN_W'(16)) && fits16) begin
            nxt_beats  = 5'd16;
            nxt_hburst = HB_INCR16;
        end else if ((remain >= LEN_W'(8)) && fits8) begin
            nxt_beats  = 5'd8;
            nxt_hburst = HB_INCR8;
        end else if ((remain >= LEN_W'(4)) && fits4) begin
            nxt_beats  = 5'd4;
            nxt_hburst = HB_INCR4;
        end else begin
            nxt_beats  = ({6'd0, remain_cap} < to_boundary) ? remain_cap : to_boundary[4:0];
            nxt_hburst = (nxt_beats == 5'd1) ? HB_SINGLE : HB_INCR;
        end
    end

    assign step         = {27'd0, o_cmd_beats} << cur_size;
    assign remain_after = remain - LEN_W'(o_cmd_beats);

    // Command handshake: o_cmd_valid rises only from CALC, and the command (all o_cmd_*)
    // holds until a cycle with o_cmd_valid && i_cmd_ready; i_cmd_ready is ignored otherwise.
    always_ff @(posedge i_hclk) begin
        if (!i_hreset_n) begin
            state        <= ST_IDLE;
            cur_addr     <= '0;
            remain       <= '0;
            cur_size     <= '0;
            o_cmd_valid  <= 1'b0;
            o_cmd_addr   <= '0;
            o_cmd_hburst <= HB_SINGLE;
            o_cmd_beats  <= '0;
            o_cmd_size   <= '0;
            o_cmd_last   <= 1'b0;
            o_done       <= 1'b0;
`ifdef AHB_SPLIT_ALIGN_CHECK_EN
            o_err        <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
`ifdef AHB_SPLIT_ALIGN_CHECK_EN
            o_err  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (i_req_valid && misaligned) begin
`ifdef AHB_SPLIT_ALIGN_CHECK_EN
                        o_err <= 1'b1;
`endif
                    end else if (i_req_valid) begin
                        cur_addr   <= i_req_addr & align_mask;
                        remain     <= i_req_len;
                        cur_size   <= i_req_size;
                        o_cmd_size <= i_req_size;
                        if (i_req_len == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    o_cmd_addr   <= cur_addr;
                    o_cmd_hburst <= nxt_hburst;
                    o_cmd_beats  <= nxt_beats;
                    o_cmd_last   <= (remain == LEN_W'(nxt_beats));
                    o_cmd_valid  <= 1'b1;
                    state        <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (i_cmd_ready) begin
                        o_cmd_valid <= 1'b0;
                        cur_addr    <= cur_addr + step;
                        remain      <= remain_after;
                        if (remain_after == '0) begin
                            o_done <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_manager_burst_splitter.sv
// Bench for ahb_manager_burst_splitter: directed plus random requests against a burst-list model.
module tb_ahb_manager_burst_splitter;

    localparam int LEN_W = 16;
`ifdef AHB_SPLIT_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_addr = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic [2:0]       req_size = '0;
    logic             cmd_valid;
    logic             cmd_ready = 1'b0;
    logic [31:0]      cmd_addr;
    logic [2:0]       cmd_hburst;
    logic [4:0]       cmd_beats;
    logic [2:0]       cmd_size;
    logic             cmd_last;
    logic             done;
    logic             err;
    logic             busy;

    ahb_manager_burst_splitter #(.LEN_W(LEN_W)) dut (
        .i_hclk       (clk),
        .i_hreset_n   (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .i_req_len    (req_len),
        .i_req_size   (req_size),
        .o_cmd_valid  (cmd_valid),
        .i_cmd_ready  (cmd_ready),
        .o_cmd_addr   (cmd_addr),
        .o_cmd_hburst (cmd_hburst),
        .o_cmd_beats  (cmd_beats),
        .o_cmd_size   (cmd_size),
        .o_cmd_last   (cmd_last),
        .o_done       (done),
        .o_err        (err),
        .o_busy       (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // scoreboard
    int pass_cnt = 0;
    int check_cnt = 0;
    logic [43:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [43:0] cmd_now();
        return {cmd_addr, cmd_hburst, cmd_beats, cmd_size, cmd_last};
    endfunction

    function automatic bit fits(input longint a, input int n, input int b);
        return ((a + longint'((n - 1) * b)) / 1024) == (a / 1024);
    endfunction

    // Reference: walk the request, choose bursts by the priority rules, emit packed commands.
    function automatic void model_request(input logic [31:0] addr, input int len, input int size);
        longint a;
        int r, b, n, btb;
        logic [2:0] hb;
        logic [31:0] a32;
        b = 1 << size;
        a = longint'(addr) - (longint'(addr) % b);
        r = len;
        while (r > 0) begin
            if (r >= 16 && fits(a, 16, b)) begin
                n = 16; hb = 3'd7;
            end else if (r >= 8 && fits(a, 8, b)) begin
                n = 8; hb = 3'd5;
            end else if (r >= 4 && fits(a, 4, b)) begin
                n = 4; hb = 3'd3;
            end else begin
                btb = int'((1024 - (a % 1024)) / b);
                n = r;
                if (n > 16) n = 16;
                if (n > btb) n = btb;
                hb = (n == 1) ? 3'd0 : 3'd1;
            end
            a32 = a[31:0];
            exp_q.push_back({a32, hb, 5'(n), 3'(size), (r == n)});
            a = (a + longint'(n * b)) % 64'h1_0000_0000;
            r = r - n;
        end
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // driver: one full request, strict cycle timing, hold = -1 for random backpressure
    task automatic run_request(input logic [31:0] addr, input int len, input int size, input int hold);
        bit rejected;
        int guard, waits;
        logic [43:0] exp_cmd, snap;
        rejected = ALIGN_CHECK && ((addr % (32'd1 << size)) != 0);
        guard = 0;
        while (!req_ready && guard < 50) begin
            tick();
            guard++;
        end
        check_eq("req_ready_idle", req_ready, 1);
        if (!rejected) model_request(addr, len, size);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = LEN_W'(len);
        req_size  = 3'(size);
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;
        if (rejected || len == 0) begin
            check_eq("done_t1", done, !rejected);
            check_eq("err_t1", err, rejected);
            check_eq("no_cmd_t1", cmd_valid, 0);
            check_eq("ready_t1", req_ready, 1);
            tick();
            check_eq("done_pulse_end", done, 0);
            check_eq("err_pulse_end", err, 0);
            check_eq("no_cmd_t2", cmd_valid, 0);
            return;
        end
        check_eq("err_none", err, 0);
        check_eq("done_early", done, 0);
        check_eq("ready_low_t1", req_ready, 0);
        check_eq("busy_t1", busy, 1);
        check_eq("valid_low_t1", cmd_valid, 0);
        tick();
        while (exp_q.size() > 0) begin
            exp_cmd = exp_q.pop_front();
            check_eq("cmd_valid", cmd_valid, 1);
            check_eq("cmd", cmd_now(), exp_cmd);
            waits = (hold >= 0) ? hold : int'($urandom_range(0, 3));
            snap = cmd_now();
            for (int w = 0; w < waits; w++) begin
                cmd_ready = 1'b0;
                req_valid = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_len   = LEN_W'($urandom_range(0, 20));
                tick();
                check_eq("hold_stable", cmd_now(), snap);
                check_eq("hold_valid", cmd_valid, 1);
                check_eq("hold_ready_low", req_ready, 0);
            end
            req_valid = 1'b0;
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            check_eq("valid_gap", cmd_valid, 0);
            if (exp_cmd[0]) begin
                check_eq("done_final", done, 1);
                check_eq("ready_final", req_ready, 1);
                check_eq("busy_final", busy, 0);
            end else begin
                check_eq("done_mid", done, 0);
                check_eq("ready_mid", req_ready, 0);
                tick();
            end
        end
        tick();
        check_eq("done_once", done, 0);
    endtask

    task automatic reset_in_issue();
        run_request_start: begin
            tick();
            req_valid = 1'b1;
            req_addr  = 32'h0000_0800;
            req_len   = LEN_W'(32);
            req_size  = 3'd2;
            tick();
            req_valid = 1'b0;
            tick();
            check_eq("rst_pre_valid", cmd_valid, 1);
        end
        rst_n = 1'b0;
        tick();
        check_eq("rst_valid", cmd_valid, 0);
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cmd", cmd_now(), 0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_after_done", done, 0);
        check_eq("rst_after_valid", cmd_valid, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int rlen, rsize;
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("reset_valid", cmd_valid, 0);
        check_eq("reset_ready", req_ready, 1);
        check_eq("reset_done", done, 0);
        check_eq("reset_err", err, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_cmd", cmd_now(), 0);
        rst_n = 1'b1;
        tick();

        run_request(32'h0000_0000, 32, 2, 0);
        run_request(32'h0000_03F0, 8, 2, 0);
        run_request(32'h0000_0100, 7, 0, 0);
        run_request(32'h0000_0200, 1, 0, 0);
        run_request(32'h0000_1000, 32, 2, 5);
        reset_in_issue();
        run_request(32'h0000_1234, 0, 1, 0);
        run_request(32'h0000_0102, 4, 2, 0);
        run_request(32'hFFFF_FFF0, 8, 2, 0);
        run_request(32'h0000_0000, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) ra = {ra[31:10], 10'(rb[9:0] | 10'h380)};
            rsize = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 3));
            if (!ALIGN_CHECK || $urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rsize) - 32'd1);
            rlen = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 70));
            run_request(ra, rlen, rsize, -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
